cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle control unit for the 16-bit CPU. It decodes the 4-bit opcode held in the instruction register and sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback. Every datapath enable and mux select comes from this block. It also handles the memory wait handshake, HALT, and illegal-opcode trapping.

## Interface
- No parameters; widths are fixed by the 16-bit ISA.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  4  IR[15:12]; stable except on IRWrite.
- Zero  in  1  ALU zero flag, valid in the same cycle.
- MemReady  in  1  memory has completed the current access this cycle.
- PCWrite, IRWrite, RegWrite, MemReq, MemWrite, IorD, RegDst, MemToReg, ALUSrcA  out  1 each  datapath enables/selects.
- ALUSrcB  out  2  00 regB, 01 constant 1, 10 sign-extended imm.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- Halted  out  1  HALT executed.
- Trap  out  1  illegal opcode seen.
- InstrCount  out  16  retired-instruction counter.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT: R-type.
  - 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 J, F HALT.
  - A–E are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- IDLE:
  - All outputs 0.
  - Goes to FETCH unconditionally.
- FETCH:
  - MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00.
  - IRWrite = PCWrite = MemReady.
  - Stays until MemReady=1, then goes to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=add; this precomputes the branch target into ALUOut.
  - J: PCWrite=1, PCSrc=10, then FETCH; J retires here.
  - HALT goes to HALT. Illegal opcodes go to TRAP. All other opcodes go to EXEC.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp from opcode (SUB=001, AND=010, OR=011, SLT=100), then WB.
  - ADDI/LW/SW: ALUSrcA=1, ALUSrcB=10, add. ADDI goes to WB; LW and SW go to MEM.
  - BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero, then FETCH; BEQ retires here.
- MEM:
  - MemReq=1, IorD=1, MemWrite=(opcode==SW).
  - Held until MemReady=1.
  - LW goes to WB. SW goes to FETCH and retires here.
- WB:
  - RegWrite=1.
  - RegDst=1 for R-type, 0 for ADDI/LW.
  - MemToReg=1 only for LW.
  - Goes to FETCH.
- HALT: Halted=1, all enables 0; terminal until reset.
- TRAP: Trap=1, all enables 0; terminal until reset.
- InstrCount:
  - Increments by 1 on the retiring edge of each completed instruction.
  - Wraps 0xFFFF to 0x0000.
  - HALT and illegal opcodes do not count.
- Outputs default to 0 in every state unless listed. Outputs are Moore, except IRWrite/PCWrite in FETCH (qualified by MemReady) and PCWrite in BEQ-EXEC (qualified by Zero).

## Timing
- Reset:
  - Reset_n low forces IDLE immediately, regardless of clock or current state, including mid-MEM with MemReq high.
  - All outputs go to 0 and InstrCount to 0 without waiting for a clock edge.
- The first FETCH is one cycle after Reset_n deasserts.
- Cycles per instruction with MemReady tied high:
  - J: 2.
  - BEQ: 3.
  - R-type, ADDI, SW: 4.
  - LW: 5.
- Each memory wait cycle adds exactly one cycle. MemReq stays high and no write enables pulse while waiting.
- MemReady is ignored outside FETCH and MEM.
- BEQ not taken: PCWrite stays 0; the PC already holds PC+1 from FETCH.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode constants;
  - state encoding (3 bits);
  - ALUOp codes;
  - ALUSrcB and PCSrc select codes.
- One combinational sub-module, cpu_alu_op_decode, maps opcode to ALUOp for the EXEC state.
- Everything else is one state register, next-state logic, output decode, and the InstrCount register.

## Test plan
- Reset, then MemReady=1, Opcode=0 (ADD):
  - Expected states: IDLE, FETCH, DECODE, EXEC (ALUOp=000, ALUSrcB=00), WB (RegWrite=1, RegDst=1).
  - InstrCount=1.
- LW (6) with MemReady low for 2 cycles in MEM:
  - MemReq=1, IorD=1 for 3 cycles, then WB with MemToReg=1, RegDst=0.
  - 7 cycles in total.
- BEQ (8), once with Zero=1 and once with Zero=0:
  - PCWrite=1 with PCSrc=01 in EXEC only when Zero=1.
  - Both return to FETCH after 3 cycles.
- Opcode B:
  - FETCH, DECODE, then TRAP; Trap=1, all enables 0, InstrCount unchanged.
  - Remains in TRAP for 10 cycles.
- Opcode F:
  - Halted=1 and remains set.
  - Reset_n pulse returns to IDLE with Halted=0.
- Preload 0xFFFF retirements via a stream of J (9):
  - The next J wraps InstrCount to 0x0000.
  - Assert Reset_n low mid-MEM of SW: MemWrite drops within the same cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the 16-bit CPU multi-cycle control unit:
//   - 4-bit opcode constants (IR[15:12])
//   - 3-bit control state encoding
//   - ALUOp, ALUSrcB and PCSrc select codes
//   - small opcode-classification helpers
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcodes; 4'hA..4'hE are unassigned and trap.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;
  localparam logic [2:0] ALUOP_SLT = 3'b100;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // R-type instructions occupy the bottom of the opcode space.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_alu_op_decode.sv
// -----------------------------------------------------------------------------
// cpu_alu_op_decode
// Combinational opcode -> ALUOp map used while the FSM is in EXEC.
//   i_opcode [3:0]  instruction opcode
//   o_alu_op [2:0]  ALU operation (add for address/immediate forms, sub for BEQ)
// -----------------------------------------------------------------------------
module cpu_alu_op_decode (
  input  logic [3:0] i_opcode,
  output logic [2:0] o_alu_op
);
  import cpu_ctrl_pkg::*;

  // Opcode to ALU operation lookup
  always_comb begin
    o_alu_op = ALUOP_ADD;
    case (i_opcode)
      OP_ADD:         o_alu_op = ALUOP_ADD;
      OP_SUB, OP_BEQ: o_alu_op = ALUOP_SUB;
      OP_AND:         o_alu_op = ALUOP_AND;
      OP_OR:          o_alu_op = ALUOP_OR;
      OP_SLT:         o_alu_op = ALUOP_SLT;
      default:        o_alu_op = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control unit for the 16-bit CPU. Sequences the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB, handles memory wait states, HALT and
// illegal-opcode trapping, and counts retired instructions.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_opcode [3:0]          IR[15:12]
//   i_zero                  ALU zero flag (same cycle)
//   i_mem_ready             memory completed the current access
//   o_pc_write .. o_alu_src_a   1-bit datapath enables/selects
//   o_alu_src_b [1:0]       00 regB, 01 const 1, 10 sign-extended imm
//   o_alu_op [2:0]          000 add, 001 sub, 010 and, 011 or, 100 slt
//   o_pc_src [1:0]          00 ALU result, 01 ALUOut, 10 jump target
//   o_halted, o_trap        terminal-state indicators
//   o_instr_count [15:0]    retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module cpu_control_fsm (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic        o_iord,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [2:0]  o_alu_op,
  output logic [1:0]  o_pc_src,
  output logic        o_halted,
  output logic        o_trap,
  output logic [15:0] o_instr_count
);
  import cpu_ctrl_pkg::*;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  w_exec_alu_op;
  logic        w_retire;
  logic [15:0] r_instr_count;

  cpu_alu_op_decode u_alu_op_decode (
    .i_opcode (i_opcode),
    .o_alu_op (w_exec_alu_op)
  );

  // State register; reset drops straight to IDLE so every output is 0 at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode (Moore, plus MemReady/Zero-qualified writes)
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_REGB;
    o_alu_op     = ALUOP_ADD;
    o_pc_src     = PCSRC_ALU;
    o_halted     = 1'b0;
    o_trap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // PC <= PC+1 is written together with IR, only on the ready cycle
        o_mem_req   = 1'b1;
        o_alu_src_b = SRCB_ONE;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        if (i_mem_ready) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // PC + imm lands in ALUOut for a possible BEQ in the next cycle
        o_alu_src_b = SRCB_IMM;
        if (i_opcode == OP_J) begin
          o_pc_write   = 1'b1;
          o_pc_src     = PCSRC_JUMP;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end else if (i_opcode == OP_HALT) begin
          w_next_state = ST_HALT;
        end else if (is_illegal(i_opcode)) begin
          w_next_state = ST_TRAP;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = w_exec_alu_op;
        if (is_rtype(i_opcode)) begin
          w_next_state = ST_WB;
        end else if (i_opcode == OP_BEQ) begin
          o_pc_src     = PCSRC_ALUOUT;
          o_pc_write   = i_zero;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end else if (i_opcode == OP_ADDI) begin
          o_alu_src_b  = SRCB_IMM;
          w_next_state = ST_WB;
        end else if ((i_opcode == OP_LW) || (i_opcode == OP_SW)) begin
          o_alu_src_b  = SRCB_IMM;
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_MEM: begin
        o_mem_req   = 1'b1;
        o_iord      = 1'b1;
        o_mem_write = (i_opcode == OP_SW);
        if (!i_mem_ready) begin
          w_next_state = ST_MEM;
        end else if (i_opcode == OP_LW) begin
          w_next_state = ST_WB;
        end else begin
          w_retire     = (i_opcode == OP_SW);
          w_next_state = ST_FETCH;
        end
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = is_rtype(i_opcode);
        o_mem_to_reg = (i_opcode == OP_LW);
        w_retire     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        o_halted     = 1'b1;
        w_next_state = ST_HALT;
      end
      ST_TRAP: begin
        o_trap       = 1'b1;
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Retired-instruction counter; natural 16-bit wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr_count <= 16'h0000;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 16'h0001;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Scoreboard bench: the driver walks each instruction through the phases the
// ISA defines, pushing the expected control word for every cycle; a monitor
// on the falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  typedef struct packed {
    logic        pcw;
    logic        irw;
    logic        rw;
    logic        mreq;
    logic        mw;
    logic        iord;
    logic        rdst;
    logic        m2r;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  aluop;
    logic [1:0]  pcsrc;
    logic        halted;
    logic        trap;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    obs_t v;
    int   ph;
    int   idx;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [3:0]  opcode    = 4'h0;
  logic        zero      = 1'b0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, reg_write, mem_req, mem_write, iord;
  logic        reg_dst, mem_to_reg, alu_src_a, halted, trap;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [15:0] instr_count;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          errors    = 0;
  logic        end_req   = 1'b0;
  logic        end_done  = 1'b0;
  logic [15:0] model_count = 16'h0000;
  logic [3:0]  cur_op    = 4'h0;
  int          instr_idx = 0;

  logic [2:0]  rtype_alu [0:4] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
  string       ph_name   [0:7] = '{"IDLE", "FETCH", "DECODE", "EXEC", "MEM", "WB", "HALT", "TRAP"};

  cpu_control_fsm dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_opcode      (opcode),
    .i_zero        (zero),
    .i_mem_ready   (mem_ready),
    .o_pc_write    (pc_write),
    .o_ir_write    (ir_write),
    .o_reg_write   (reg_write),
    .o_mem_req     (mem_req),
    .o_mem_write   (mem_write),
    .o_iord        (iord),
    .o_reg_dst     (reg_dst),
    .o_mem_to_reg  (mem_to_reg),
    .o_alu_src_a   (alu_src_a),
    .o_alu_src_b   (alu_src_b),
    .o_alu_op      (alu_op),
    .o_pc_src      (pc_src),
    .o_halted      (halted),
    .o_trap        (trap),
    .o_instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT control word with the next expected entry
  obs_t mon_act;
  exp_t mon_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {pc_write, ir_write, reg_write, mem_req, mem_write, iord,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                 halted, trap, instr_count};
      checks = checks + 1;
      if (mon_act !== mon_exp.v) begin
        errors = errors + 1;
        $display("FAIL %s instr#%0d t=%0t got=%h expected=%h (count got %h expected %h)",
                 ph_name[mon_exp.ph], mon_exp.idx, $time, mon_act, mon_exp.v,
                 mon_act.cnt, mon_exp.v.cnt);
      end
    end
    if (end_req && !end_done) begin
      checks = checks + 1;
      if (exp_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  function automatic logic rbit();
    return ($urandom_range(1, 0) != 0);
  endfunction

  task automatic push_exp(input obs_t e, input int ph);
    exp_t x;
    x.v   = e;
    x.ph  = ph;
    x.idx = instr_idx;
    exp_q.push_back(x);
  endtask

  task automatic drive_cycle(input logic rdy, input logic z, input logic [3:0] op,
                             input obs_t e, input int ph);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    push_exp(e, ph);
  endtask

  task automatic retire();
    model_count = model_count + 16'd1;
  endtask

  task automatic reset_assert();
    obs_t e;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    model_count = 16'h0000;
    e = '0;
    push_exp(e, 0);
  endtask

  // Hold reset one more cycle, then release; the release cycle is IDLE.
  task automatic reset_release(input logic preload);
    obs_t e;
    e = '0;
    drive_cycle(rbit(), rbit(), cur_op, e, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (preload) begin
      force dut.r_instr_count = 16'hFFF0;
      #1;
      release dut.r_instr_count;
      model_count = 16'hFFF0;
    end
    e.cnt = model_count;
    push_exp(e, 0);
  endtask

  task automatic hold_terminal(input int n, input logic h, input logic t, input int ph);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.halted = h;
      e.trap   = t;
      e.cnt    = model_count;
      drive_cycle(rbit(), rbit(), cur_op, e, ph);
    end
  endtask

  // One instruction, phase by phase, as the ISA describes it.
  task automatic run_instr(input logic [3:0] op, input int fwait, input int mwait,
                           input logic z, input logic abort_mem);
    obs_t e;
    logic rdy;
    logic rt;
    instr_idx = instr_idx + 1;
    rt = (op <= 4'd4);
    for (int i = 0; i <= fwait; i++) begin
      rdy = (i == fwait);
      e = '0;
      e.mreq = 1'b1;
      e.srcb = 2'b01;
      e.irw  = rdy;
      e.pcw  = rdy;
      e.cnt  = model_count;
      drive_cycle(rdy, rbit(), rdy ? op : cur_op, e, 1);
    end
    cur_op = op;
    e = '0;
    e.srcb = 2'b10;
    e.cnt  = model_count;
    if (op == 4'd9) begin
      e.pcw   = 1'b1;
      e.pcsrc = 2'b10;
    end
    drive_cycle(rbit(), rbit(), op, e, 2);
    if (op == 4'd9) begin
      retire();
      return;
    end
    if (op >= 4'd10) return;
    e = '0;
    e.srca = 1'b1;
    e.cnt  = model_count;
    if (rt) begin
      e.aluop = rtype_alu[int'(op)];
    end else if (op == 4'd8) begin
      e.aluop = 3'b001;
      e.pcsrc = 2'b01;
      e.pcw   = z;
    end else begin
      e.srcb = 2'b10;
    end
    drive_cycle(rbit(), z, op, e, 3);
    if (op == 4'd8) begin
      retire();
      return;
    end
    if ((op == 4'd6) || (op == 4'd7)) begin
      for (int i = 0; i <= mwait; i++) begin
        if (abort_mem && (i == 1)) begin
          reset_assert();
          return;
        end
        rdy = (i == mwait);
        e = '0;
        e.mreq = 1'b1;
        e.iord = 1'b1;
        e.mw   = (op == 4'd7);
        e.cnt  = model_count;
        drive_cycle(rdy, rbit(), op, e, 4);
      end
      if (op == 4'd7) begin
        retire();
        return;
      end
    end
    e = '0;
    e.rw  = 1'b1;
    e.rdst = rt;
    e.m2r = (op == 4'd6);
    e.cnt = model_count;
    drive_cycle(rbit(), rbit(), op, e, 5);
    retire();
  endtask

  initial begin
    obs_t e;
    // Reset, then ADD / LW with waits / BEQ taken and not taken
    reset_assert();
    reset_release(1'b0);
    run_instr(4'h0, 0, 0, 1'b0, 1'b0);
    run_instr(4'h6, 0, 2, 1'b0, 1'b0);
    run_instr(4'h8, 0, 0, 1'b1, 1'b0);
    run_instr(4'h8, 0, 0, 1'b0, 1'b0);

    // Random legal instruction stream with random wait states
    for (int k = 0; k < 200; k++) begin
      run_instr(4'($urandom_range(9, 0)), int'($urandom_range(2, 0)),
                int'($urandom_range(2, 0)), rbit(), 1'b0);
    end

    // SW interrupted by reset while waiting in MEM
    run_instr(4'h7, 1, 3, 1'b0, 1'b1);
    reset_release(1'b1);

    // J stream across the counter wrap
    for (int k = 0; k < 18; k++) begin
      run_instr(4'h9, int'($urandom_range(1, 0)), 0, 1'b0, 1'b0);
    end

    // Illegal opcodes trap and stay there
    run_instr(4'hB, 0, 0, 1'b0, 1'b0);
    hold_terminal(10, 1'b0, 1'b1, 7);
    reset_assert();
    reset_release(1'b0);
    run_instr(4'h2, 0, 0, 1'b0, 1'b0);
    run_instr(4'($urandom_range(14, 10)), 1, 0, 1'b0, 1'b0);
    hold_terminal(3, 1'b0, 1'b1, 7);

    // HALT is terminal until reset
    reset_assert();
    reset_release(1'b0);
    run_instr(4'h5, 0, 0, 1'b0, 1'b0);
    run_instr(4'hF, 0, 0, 1'b0, 1'b0);
    hold_terminal(6, 1'b1, 1'b0, 6);
    reset_assert();
    reset_release(1'b0);
    run_instr(4'h4, 1, 0, 1'b0, 1'b0);
    run_instr(4'h9, 0, 0, 1'b0, 1'b0);
    e = '0;
    e.mreq = 1'b1;
    e.srcb = 2'b01;
    e.cnt  = model_count;
    drive_cycle(1'b0, 1'b0, cur_op, e, 1);
    end_req = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    if (!end_done) begin
      $display("FAIL monitor: end-of-run check not reached");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
